// File: rtl/r_id_ex_hazard_if.sv
// ID/EX pipeline bundle: ID-side inputs, EX-side registered outputs, hazard status.
// Optional o_bubble_cnt member exists only when R_ID_EX_HAZARD_STAT_EN is defined.
interface r_id_ex_hazard_if;
  logic [31:0] i_pc_plus4;
  logic [31:0] i_read_data1;
  logic [31:0] i_read_data2;
  logic [31:0] i_imm;
  logic [4:0]  i_rs;
  logic [4:0]  i_rt;
  logic [4:0]  i_rd;
  logic [1:0]  i_WB_control;
  logic [2:0]  i_MEM_control;
  logic [3:0]  i_EX_control;
  logic        i_flush;

  logic [31:0] o_pc_plus4;
  logic [31:0] o_read_data1;
  logic [31:0] o_read_data2;
  logic [31:0] o_imm;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [1:0]  o_WB_control;
  logic [2:0]  o_MEM_control;
  logic [3:0]  o_EX_control;
  logic [4:0]  o_write_reg;
  logic        o_stall;
  logic        o_valid;
`ifdef R_ID_EX_HAZARD_STAT_EN
  logic [15:0] o_bubble_cnt;
`endif

  modport master (
    output i_pc_plus4, i_read_data1, i_read_data2, i_imm, i_rs, i_rt, i_rd,
           i_WB_control, i_MEM_control, i_EX_control, i_flush,
    input  o_pc_plus4, o_read_data1, o_read_data2, o_imm, o_rs, o_rt, o_rd,
           o_WB_control, o_MEM_control, o_EX_control, o_write_reg, o_stall, o_valid
`ifdef R_ID_EX_HAZARD_STAT_EN
           , o_bubble_cnt
`endif
  );

  modport slave (
    input  i_pc_plus4, i_read_data1, i_read_data2, i_imm, i_rs, i_rt, i_rd,
           i_WB_control, i_MEM_control, i_EX_control, i_flush,
    output o_pc_plus4, o_read_data1, o_read_data2, o_imm, o_rs, o_rt, o_rd,
           o_WB_control, o_MEM_control, o_EX_control, o_write_reg, o_stall, o_valid
`ifdef R_ID_EX_HAZARD_STAT_EN
           , o_bubble_cnt
`endif
  );
endinterface

// File: rtl/r_id_ex_hazard.sv
// ID/EX pipeline register with load-use hazard detection and flush-to-bubble.
// Define R_ID_EX_HAZARD_STAT_EN to add the saturating o_bubble_cnt statistic.
module r_id_ex_hazard (
  input  logic             i_clk,
  input  logic             i_rst_n,
  r_id_ex_hazard_if.slave  bus
);

  logic [31:0] r_pc_plus4;
  logic [31:0] r_read_data1;
  logic [31:0] r_read_data2;
  logic [31:0] r_imm;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [4:0]  r_write_reg;
  logic [1:0]  r_wb_ctrl;
  logic [2:0]  r_mem_ctrl;
  logic [3:0]  r_ex_ctrl;
  logic        r_valid;

  logic        w_rt_match;
  logic        w_stall;
  logic        w_bubble;

  // A load in EX whose destination feeds the ID instruction must hold IF/ID; flush overrides.
  assign w_rt_match = (r_rt == bus.i_rs) | (r_rt == bus.i_rt);
  assign w_stall    = r_valid & r_mem_ctrl[1] & (r_rt != 5'd0) & w_rt_match & ~bus.i_flush;
  assign w_bubble   = w_stall | bus.i_flush;

  // Pipeline register: data always follows ID, control is zeroed when a bubble is inserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_plus4   <= 32'd0;
      r_read_data1 <= 32'd0;
      r_read_data2 <= 32'd0;
      r_imm        <= 32'd0;
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_rd         <= 5'd0;
      r_write_reg  <= 5'd0;
      r_wb_ctrl    <= 2'd0;
      r_mem_ctrl   <= 3'd0;
      r_ex_ctrl    <= 4'd0;
      r_valid      <= 1'b0;
    end else begin
      r_pc_plus4   <= bus.i_pc_plus4;
      r_read_data1 <= bus.i_read_data1;
      r_read_data2 <= bus.i_read_data2;
      r_imm        <= bus.i_imm;
      r_rs         <= bus.i_rs;
      r_rt         <= bus.i_rt;
      r_rd         <= bus.i_rd;
      r_write_reg  <= bus.i_EX_control[3] ? bus.i_rd : bus.i_rt;
      if (w_bubble) begin
        r_wb_ctrl  <= 2'd0;
        r_mem_ctrl <= 3'd0;
        r_ex_ctrl  <= 4'd0;
        r_valid    <= 1'b0;
      end else begin
        r_wb_ctrl  <= bus.i_WB_control;
        r_mem_ctrl <= bus.i_MEM_control;
        r_ex_ctrl  <= bus.i_EX_control;
        r_valid    <= 1'b1;
      end
    end
  end

  assign bus.o_pc_plus4    = r_pc_plus4;
  assign bus.o_read_data1  = r_read_data1;
  assign bus.o_read_data2  = r_read_data2;
  assign bus.o_imm         = r_imm;
  assign bus.o_rs          = r_rs;
  assign bus.o_rt          = r_rt;
  assign bus.o_rd          = r_rd;
  assign bus.o_write_reg   = r_write_reg;
  assign bus.o_WB_control  = r_wb_ctrl;
  assign bus.o_MEM_control = r_mem_ctrl;
  assign bus.o_EX_control  = r_ex_ctrl;
  assign bus.o_valid       = r_valid;
  assign bus.o_stall       = w_stall;

`ifdef R_ID_EX_HAZARD_STAT_EN
  logic [15:0] r_bubble_cnt;

  // Count every bubble edge (stall or flush), saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bubble_cnt <= 16'd0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.o_bubble_cnt = r_bubble_cnt;
`else
  // Statistics disabled: no counter state or port.
`endif

endmodule
